hazard_unit: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core: it replaces the purely combinational hazard checker with a clocked unit. It decodes operand dependencies in ID and registers the forwarding selects for EX. It inserts load-use stalls, squashes wrong-path instructions for a parametrised number of fetch cycles after a redirect, and honours a global memory freeze. It sits beside the ID/EX pipeline register and drives the PC, IF/ID and ID/EX control inputs and the EX operand muxes.

---
 rtl/hazard_pkg.sv | 31 +++
 rtl/hazard_if.sv | 43 ++++
 rtl/hazard_dep_cmp.sv | 12 +
 rtl/hazard_unit.sv | 135 +++++++++++++
 tb/tb_hazard_unit.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forward selects, FSM states, bubble NOP.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // addi x0, x0, 0 -- what the ID/EX register loads on a bubble
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    localparam int FCNT_W = 2;

    // The younger producer (in EX, reaching MEM next cycle) shadows the older one.
    function automatic fwd_sel_t pick_sel(input logic ex_hit, input logic mem_hit);
        if (ex_hit) begin
            return FWD_MEM;
        end
        if (mem_hit) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_if.sv
// Pipeline-side signals of the hazard controller: operand/producer info in, stall/flush/forward out.
interface hazard_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] ex_rd;
    logic [REG_AW-1:0] mem_rd;
    logic              ex_regwrite;
    logic              mem_regwrite;
    logic              ex_memread;
    logic              ex_redirect;
    logic              mem_busy;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              pc_stall;
    logic              ifid_stall;
    logic              idex_stall;
    logic              idex_bubble;
    logic              flush_ifid;
    logic              flush_idex;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output ex_rd, mem_rd, ex_regwrite, mem_regwrite,
        output ex_memread, ex_redirect, mem_busy,
        input  fwd_a_sel, fwd_b_sel, pc_stall, ifid_stall, idex_stall,
        input  idex_bubble, flush_ifid, flush_idex, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  ex_rd, mem_rd, ex_regwrite, mem_regwrite,
        input  ex_memread, ex_redirect, mem_busy,
        output fwd_a_sel, fwd_b_sel, pc_stall, ifid_stall, idex_stall,
        output idex_bubble, flush_ifid, flush_idex, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_dep_cmp.sv
// Matches one ID source operand against one in-flight producer; x0 never matches.
module hazard_dep_cmp #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic              used_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              regwrite_i,
    output logic              match_o
);
    assign match_o = used_i && (rs_i != '0) && regwrite_i && (rd_i == rs_i);
endmodule

// File: rtl/hazard_unit.sv
// Clocked hazard controller: registered EX forward selects, load-use stalls,
// post-redirect squash sequencing and memory freeze.
//
//   state    | meaning
//   ST_RUN   | normal issue; load-use / no-forwarding stalls honoured
//   ST_FLUSH | squashing IF/ID for fcnt more cycles after a redirect
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int FWD_EN       = 1,
    parameter int CNT_W        = 16
) (
    input logic     clk,
    input logic     rst,
    hazard_if.slave hz
);
    logic a_ex, a_mem, b_ex, b_mem;
    logic dep_ex, dep_mem, stall_req;

    state_t            state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    fwd_sel_t          fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
    logic              stall_ev, flush_ev;
    logic              pc_stall, ifid_stall, idex_stall, idex_bubble, flush_ifid, flush_idex;

    hazard_dep_cmp #(.REG_AW(REG_AW)) u_cmp_a_ex (
        .rs_i(hz.id_rs1), .used_i(hz.id_rs1_used), .rd_i(hz.ex_rd),
        .regwrite_i(hz.ex_regwrite), .match_o(a_ex));
    hazard_dep_cmp #(.REG_AW(REG_AW)) u_cmp_a_mem (
        .rs_i(hz.id_rs1), .used_i(hz.id_rs1_used), .rd_i(hz.mem_rd),
        .regwrite_i(hz.mem_regwrite), .match_o(a_mem));
    hazard_dep_cmp #(.REG_AW(REG_AW)) u_cmp_b_ex (
        .rs_i(hz.id_rs2), .used_i(hz.id_rs2_used), .rd_i(hz.ex_rd),
        .regwrite_i(hz.ex_regwrite), .match_o(b_ex));
    hazard_dep_cmp #(.REG_AW(REG_AW)) u_cmp_b_mem (
        .rs_i(hz.id_rs2), .used_i(hz.id_rs2_used), .rd_i(hz.mem_rd),
        .regwrite_i(hz.mem_regwrite), .match_o(b_mem));

    assign dep_ex  = a_ex || b_ex;
    assign dep_mem = a_mem || b_mem;
    // Without forwarding every in-flight producer blocks ID until it reaches WB.
    assign stall_req = (FWD_EN != 0) ? (dep_ex && hz.ex_memread) : (dep_ex || dep_mem);

    // Priority: freeze > redirect > flush sequence > stall.
    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        idex_bubble = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        stall_ev    = 1'b0;
        flush_ev    = 1'b0;
        if (hz.mem_busy) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_stall = 1'b1;
        end else if (hz.ex_redirect) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            flush_ev   = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = ST_FLUSH;
                fcnt_d  = FCNT_W'(FLUSH_CYCLES - 1);
            end else begin
                state_d = ST_RUN;
                fcnt_d  = '0;
            end
        end else if (state_q == ST_FLUSH) begin
            flush_ifid = 1'b1;
            fcnt_d     = fcnt_q - 2'd1;
            if (fcnt_q <= 2'd1) begin
                state_d = ST_RUN;
                fcnt_d  = '0;
            end
        end else if (stall_req) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
            stall_ev    = 1'b1;
        end
    end

    always_comb begin
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (!idex_stall) begin
            if (idex_bubble || flush_idex || (FWD_EN == 0)) begin
                fwd_a_d = FWD_REG;
                fwd_b_d = FWD_REG;
            end else begin
                fwd_a_d = pick_sel(a_ex, a_mem);
                fwd_b_d = pick_sel(b_ex, b_mem);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            fcnt_q      <= '0;
            fwd_a_q     <= FWD_REG;
            fwd_b_q     <= FWD_REG;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            if (stall_ev && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_ev && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign hz.fwd_a_sel   = fwd_a_q;
    assign hz.fwd_b_sel   = fwd_b_q;
    assign hz.pc_stall    = pc_stall;
    assign hz.ifid_stall  = ifid_stall;
    assign hz.idex_stall  = idex_stall;
    assign hz.idex_bubble = idex_bubble;
    assign hz.flush_ifid  = flush_ifid;
    assign hz.flush_idex  = flush_idex;
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed scoreboard bench: dut0 forwards with a 3-cycle flush, dut1 has forwarding disabled.
module tb_hazard_unit;
    import hazard_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;

    hazard_if #(.REG_AW(5), .CNT_W(16)) if0 ();
    hazard_if #(.REG_AW(5), .CNT_W(16)) if1 ();

    hazard_unit #(.REG_AW(5), .FLUSH_CYCLES(3), .FWD_EN(1), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst0), .hz(if0));
    hazard_unit #(.REG_AW(5), .FLUSH_CYCLES(1), .FWD_EN(0), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst1), .hz(if1));

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] exrd;
        logic       exw, exmr;
        logic [4:0] memrd;
        logic       memw, redir, busy;
    } in_t;

    typedef struct packed {
        logic [1:0]  fa, fb;
        logic        pcs, ifs, ids, bub, fif, fid;
        logic [15:0] sc, fc;
    } out_t;

    typedef struct {
        bit   w;
        int   id;
        out_t o;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    out_t act;
    int   checks = 0;
    int   errors = 0;

    function automatic in_t mk(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] exrd,
                               input logic exw, input logic exmr, input logic [4:0] memrd,
                               input logic memw, input logic redir, input logic busy);
        in_t v;
        v = '{rst:rst, rs1:rs1, rs2:rs2, u1:u1, u2:u2, exrd:exrd, exw:exw, exmr:exmr,
              memrd:memrd, memw:memw, redir:redir, busy:busy};
        return v;
    endfunction

    function automatic out_t ex(input logic [1:0] fa, input logic [1:0] fb,
                                input logic pcs, input logic ifs, input logic ids,
                                input logic bub, input logic fif, input logic fid,
                                input logic [15:0] sc, input logic [15:0] fc);
        out_t o;
        o = '{fa:fa, fb:fb, pcs:pcs, ifs:ifs, ids:ids, bub:bub, fif:fif, fid:fid, sc:sc, fc:fc};
        return o;
    endfunction

    task automatic drive(input bit w, input in_t v);
        if (w == 1'b0) begin
            rst0 = v.rst;
            if0.id_rs1 = v.rs1;        if0.id_rs2 = v.rs2;
            if0.id_rs1_used = v.u1;    if0.id_rs2_used = v.u2;
            if0.ex_rd = v.exrd;        if0.ex_regwrite = v.exw;
            if0.ex_memread = v.exmr;   if0.mem_rd = v.memrd;
            if0.mem_regwrite = v.memw; if0.ex_redirect = v.redir;
            if0.mem_busy = v.busy;
        end else begin
            rst1 = v.rst;
            if1.id_rs1 = v.rs1;        if1.id_rs2 = v.rs2;
            if1.id_rs1_used = v.u1;    if1.id_rs2_used = v.u2;
            if1.ex_rd = v.exrd;        if1.ex_regwrite = v.exw;
            if1.ex_memread = v.exmr;   if1.mem_rd = v.memrd;
            if1.mem_regwrite = v.memw; if1.ex_redirect = v.redir;
            if1.mem_busy = v.busy;
        end
    endtask

    // Inputs change just after the edge; the expectation covers that whole cycle.
    task automatic step(input bit w, input int id, input in_t v, input bit chk, input out_t o);
        exp_t e;
        @(posedge clk);
        #1;
        drive(w, v);
        if (chk) begin
            e.w  = w;
            e.id = id;
            e.o  = o;
            sb.push_back(e);
        end
    endtask

    task automatic cmp(input string nm, input int id, input logic [15:0] a, input logic [15:0] r);
        checks++;
        if (a !== r) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, id, a, r);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            if (mon_e.w == 1'b0) begin
                act = '{fa:if0.fwd_a_sel, fb:if0.fwd_b_sel, pcs:if0.pc_stall, ifs:if0.ifid_stall,
                        ids:if0.idex_stall, bub:if0.idex_bubble, fif:if0.flush_ifid,
                        fid:if0.flush_idex, sc:if0.stall_cnt, fc:if0.flush_cnt};
            end else begin
                act = '{fa:if1.fwd_a_sel, fb:if1.fwd_b_sel, pcs:if1.pc_stall, ifs:if1.ifid_stall,
                        ids:if1.idex_stall, bub:if1.idex_bubble, fif:if1.flush_ifid,
                        fid:if1.flush_idex, sc:if1.stall_cnt, fc:if1.flush_cnt};
            end
            cmp("fwd_a_sel",   mon_e.id, 16'(act.fa),  16'(mon_e.o.fa));
            cmp("fwd_b_sel",   mon_e.id, 16'(act.fb),  16'(mon_e.o.fb));
            cmp("pc_stall",    mon_e.id, 16'(act.pcs), 16'(mon_e.o.pcs));
            cmp("ifid_stall",  mon_e.id, 16'(act.ifs), 16'(mon_e.o.ifs));
            cmp("idex_stall",  mon_e.id, 16'(act.ids), 16'(mon_e.o.ids));
            cmp("idex_bubble", mon_e.id, 16'(act.bub), 16'(mon_e.o.bub));
            cmp("flush_ifid",  mon_e.id, 16'(act.fif), 16'(mon_e.o.fif));
            cmp("flush_idex",  mon_e.id, 16'(act.fid), 16'(mon_e.o.fid));
            cmp("stall_cnt",   mon_e.id, act.sc, mon_e.o.sc);
            cmp("flush_cnt",   mon_e.id, act.fc, mon_e.o.fc);
        end
    end

    initial begin
        in_t  idle, rstv;
        out_t z;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rstv = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        z    = ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("info: bubble encoding %h", NOP_INSN);
        drive(0, rstv);
        drive(1, rstv);

        // dut0: forwarding, FLUSH_CYCLES=3
        step(0, 1,  rstv, 1, z);
        step(0, 2,  mk(0, 5, 7, 1, 1, 5, 1, 0, 0, 0, 0, 0), 1, z);
        step(0, 3,  mk(0, 9, 5, 1, 1, 6, 1, 0, 5, 1, 0, 0), 1, ex(2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 4,  idle,                                   1, ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 5,  mk(0, 3, 3, 1, 1, 3, 1, 1, 0, 0, 0, 0), 1, ex(0, 0, 1, 1, 0, 1, 0, 0, 0, 0));
        step(0, 6,  mk(0, 3, 3, 1, 1, 0, 0, 0, 3, 1, 0, 0), 1, ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        step(0, 7,  idle,                                   1, ex(1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        step(0, 8,  mk(0, 0, 0, 1, 1, 0, 1, 1, 0, 1, 0, 0), 1, ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        step(0, 9,  idle,                                   1, ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        step(0, 10, mk(0, 3, 0, 1, 0, 3, 1, 1, 0, 0, 1, 0), 1, ex(0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
        step(0, 11, mk(0, 3, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0), 1, ex(0, 0, 0, 0, 0, 0, 1, 0, 1, 1));
        step(0, 12, idle,                                   1, ex(2, 0, 0, 0, 0, 0, 1, 0, 1, 1));
        step(0, 13, idle,                                   1, ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        step(0, 14, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1, ex(0, 0, 0, 0, 0, 0, 1, 1, 1, 1));
        step(0, 15, mk(0, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0), 1, ex(0, 0, 0, 0, 0, 0, 1, 0, 1, 2));
        step(0, 16, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1, ex(2, 0, 1, 1, 1, 0, 0, 0, 1, 2));
        step(0, 17, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 1, ex(2, 0, 1, 1, 1, 0, 0, 0, 1, 2));
        step(0, 18, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1, ex(2, 0, 1, 1, 1, 0, 0, 0, 1, 2));
        step(0, 19, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1, ex(2, 0, 1, 1, 1, 0, 0, 0, 1, 2));
        step(0, 20, idle,                                   1, ex(2, 0, 0, 0, 0, 0, 1, 0, 1, 2));
        step(0, 21, idle,                                   1, ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 2));

        // dut1: forwarding disabled, FLUSH_CYCLES=1
        step(1, 101, rstv,                                   1, z);
        step(1, 102, mk(0, 5, 7, 1, 1, 5, 1, 0, 0, 0, 0, 0), 1, ex(0, 0, 1, 1, 0, 1, 0, 0, 0, 0));
        step(1, 103, mk(0, 5, 7, 1, 1, 0, 0, 0, 5, 1, 0, 0), 1, ex(0, 0, 1, 1, 0, 1, 0, 0, 1, 0));
        step(1, 104, mk(0, 5, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0), 1, ex(0, 0, 0, 0, 0, 0, 0, 0, 2, 0));
        step(1, 105, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1, ex(0, 0, 0, 0, 0, 0, 1, 1, 2, 0));
        step(1, 106, idle,                                   1, ex(0, 0, 0, 0, 0, 0, 0, 0, 2, 1));
        step(1, 107, mk(0, 0, 9, 0, 1, 9, 1, 0, 0, 0, 0, 0), 1, ex(0, 0, 1, 1, 0, 1, 0, 0, 2, 1));
        step(1, 108, mk(1, 0, 9, 0, 1, 9, 1, 0, 0, 0, 0, 0), 0, z);
        step(1, 109, idle,                                   1, z);

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clk);
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations pending, required 0", sb.size());
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
